// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul engine.
// Optional accumulate mode is enabled with MATMUL_ACC_EN.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MM_DIM    = 4;
    localparam int MM_DATA_W = 32;
    localparam int MM_LANES  = 4;
    localparam int MM_ELEMS  = MM_DIM * MM_DIM;
    localparam int MM_STEPS  = MM_ELEMS / MM_LANES;

    function automatic int mm_idx_w(input int elems);
        return (elems > 2) ? $clog2(elems) : 1;
    endfunction

    localparam int MM_IDX_W = mm_idx_w(MM_ELEMS);

endpackage

// File: rtl/matmul_dot.sv
// Combinational DIM-wide dot product, truncated to DATA_W bits.
// One instance per lane; operand selection lives in the parent.
module matmul_dot
    import matmul_pkg::*;
#(
    parameter int DIM    = MM_DIM,
    parameter int DATA_W = MM_DATA_W
) (
    input  logic [DIM*DATA_W-1:0] a_row,
    input  logic [DIM*DATA_W-1:0] b_col,
    output logic [DATA_W-1:0]     dot
);

    logic [DATA_W-1:0] prod [DIM];

    always_comb begin
        for (int j = 0; j < DIM; j++) begin
            prod[j] = a_row[j*DATA_W +: DATA_W] * b_col[j*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        dot = '0;
        for (int j = 0; j < DIM; j++) begin
            dot = dot + prod[j];
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// C = A x B over DIM x DIM matrices using LANES dot-product units.
// Defining MATMUL_ACC_EN adds acc_mode (C += A x B).
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DIM    = MM_DIM,
    parameter int DATA_W = MM_DATA_W,
    parameter int LANES  = MM_LANES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
`ifdef MATMUL_ACC_EN
    input  logic                        acc_mode,
`endif
    input  logic [2*DIM*DIM*DATA_W-1:0] in_matrix,
    output logic                        busy,
    output logic                        done,
    output logic [DIM*DIM*DATA_W-1:0]   out_matrix
);

    localparam int ELEMS = DIM * DIM;
    localparam int IDX_W = mm_idx_w(ELEMS);
    localparam int VEC   = ELEMS * DATA_W;

    if ((ELEMS % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide DIM*DIM");
    end
    if (DIM < 2 || DIM > 16) begin : g_bad_dim
        $error("DIM must be within 2..16");
    end

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VEC-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
    logic              done_q, done_d;
    logic              accept, last;
`ifdef MATMUL_ACC_EN
    logic              acc_q, acc_d;
`endif

    logic [DIM*DATA_W-1:0] row_v [LANES];
    logic [DIM*DATA_W-1:0] col_v [LANES];
    logic [DATA_W-1:0]     dot_v [LANES];

    assign accept = start && (state_q != CALC);
    assign last   = (idx_q == IDX_W'(ELEMS - LANES));

    // Lane l works on element idx+l: row r of A against column k of B
    always_comb begin
        int e, r, k;
        for (int l = 0; l < LANES; l++) begin
            e = int'(idx_q) + l;
            r = e / DIM;
            k = e % DIM;
            row_v[l] = '0;
            col_v[l] = '0;
            for (int j = 0; j < DIM; j++) begin
                row_v[l][j*DATA_W +: DATA_W] = a_q[(r*DIM+j)*DATA_W +: DATA_W];
                col_v[l][j*DATA_W +: DATA_W] = b_q[(j*DIM+k)*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        matmul_dot #(
            .DIM    (DIM),
            .DATA_W (DATA_W)
        ) u_dot (
            .a_row (row_v[l]),
            .b_col (col_v[l]),
            .dot   (dot_v[l])
        );
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        idx_d = idx_q;
`ifdef MATMUL_ACC_EN
        acc_d = acc_q;
`endif
        if (accept) begin
            a_d   = in_matrix[VEC-1:0];
            b_d   = in_matrix[2*VEC-1:VEC];
            idx_d = '0;
`ifdef MATMUL_ACC_EN
            acc_d = acc_mode;
`endif
        end else if (state_q == CALC) begin
            for (int l = 0; l < LANES; l++) begin
`ifdef MATMUL_ACC_EN
                c_d[(int'(idx_q)+l)*DATA_W +: DATA_W] = dot_v[l] +
                    (acc_q ? c_q[(int'(idx_q)+l)*DATA_W +: DATA_W] : '0);
`else
                c_d[(int'(idx_q)+l)*DATA_W +: DATA_W] = dot_v[l];
`endif
            end
            if (!last) idx_d = idx_q + IDX_W'(LANES);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last)  state_d = DONE;
            DONE:    if (start) state_d = CALC;
            default: state_d = IDLE;
        endcase
    end

    // done lags the DONE state by one cycle, so it also drops one cycle late
    always_comb begin
        busy   = (state_q == CALC);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

`ifdef MATMUL_ACC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc_q <= 1'b0;
        else        acc_q <= acc_d;
    end
`endif

    assign done       = done_q;
    assign out_matrix = c_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine (LANES=4 and LANES=1 instances).
// Results are checked against a plain arithmetic matrix-product model.
module tb_matmul_engine;

    localparam int D = 4;
    localparam int W = 32;
    localparam int E = D * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, start0, start1;
    logic [2*E*W-1:0] in_m;
    logic             busy0, done0, busy1, done1;
    logic [E*W-1:0]   out0, out1;
`ifdef MATMUL_ACC_EN
    logic             acc_mode;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bit [31:0] ma [E];
    bit [31:0] mb [E];
    bit [31:0] exp_c [E];

    matmul_engine #(.DIM(D), .DATA_W(W), .LANES(4)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .start      (start0),
`ifdef MATMUL_ACC_EN
        .acc_mode   (acc_mode),
`endif
        .in_matrix  (in_m),
        .busy       (busy0),
        .done       (done0),
        .out_matrix (out0)
    );

    matmul_engine #(.DIM(D), .DATA_W(W), .LANES(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
`ifdef MATMUL_ACC_EN
        .acc_mode   (acc_mode),
`endif
        .in_matrix  (in_m),
        .busy       (busy1),
        .done       (done1),
        .out_matrix (out1)
    );

    function automatic void load_in();
        for (int e = 0; e < E; e++) begin
            in_m[e*W +: W]     = ma[e];
            in_m[E*W+e*W +: W] = mb[e];
        end
    endfunction

    function automatic void model(input bit acc);
        bit [31:0] s;
        for (int r = 0; r < D; r++) begin
            for (int k = 0; k < D; k++) begin
                s = acc ? exp_c[r*D+k] : 32'd0;
                for (int j = 0; j < D; j++) s = s + ma[r*D+j] * mb[j*D+k];
                exp_c[r*D+k] = s;
            end
        end
    endfunction

    task automatic launch0(output int lat, output int bcyc);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        lat  = 0;
        bcyc = busy0 ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy0) bcyc++;
            if (done0) break;
        end
    endtask

    task automatic test_reset();
        n_cmp += 6;
        if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done0: got %b want 0", done0); end
        if (out0 !== '0)    begin n_bad++; $display("FAIL reset_out0: got nonzero want 0"); end
        if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done1: got %b want 0", done1); end
        if (out1 !== '0)    begin n_bad++; $display("FAIL reset_out1: got nonzero want 0"); end
    endtask

    task automatic test_identity();
        int lat, bc;
        for (int e = 0; e < E; e++) begin
            ma[e] = (e / D == e % D) ? 32'd1 : 32'd0;
            mb[e] = 32'(e + 1);
        end
        model(1'b0);
        load_in();
        launch0(lat, bc);
        n_cmp += 2;
        if (lat !== 5) begin n_bad++; $display("FAIL ident_latency: got %0d want 5", lat); end
        if (bc !== 4)  begin n_bad++; $display("FAIL ident_busy_cycles: got %0d want 4", bc); end
        for (int e = 0; e < E; e++) begin
            n_cmp++;
            if (out0[e*W +: W] !== 32'(e + 1)) begin
                n_bad++;
                $display("FAIL ident_c%0d: got %h want %h", e, out0[e*W +: W], 32'(e + 1));
            end
        end
    endtask

    task automatic test_const_hold();
        int lat, bc;
        for (int e = 0; e < E; e++) begin ma[e] = 32'd2; mb[e] = 32'd3; end
        model(1'b0);
        load_in();
        launch0(lat, bc);
        in_m = '0;
        repeat (6) @(negedge clk);
        n_cmp += 2;
        if (lat !== 5)    begin n_bad++; $display("FAIL const_latency: got %0d want 5", lat); end
        if (done0 !== 1'b1) begin n_bad++; $display("FAIL const_done_hold: got %b want 1", done0); end
        for (int e = 0; e < E; e++) begin
            n_cmp++;
            if (out0[e*W +: W] !== 32'h18 || exp_c[e] !== 32'h18) begin
                n_bad++;
                $display("FAIL const_c%0d: got %h want %h", e, out0[e*W +: W], 32'h18);
            end
        end
    endtask

    task automatic test_wrap();
        int lat, bc;
        bit [31:0] av [2];
        bit [31:0] bv [2];
        bit [31:0] cv [2];
        av[0] = 32'h0001_0000; bv[0] = 32'h0001_0000; cv[0] = 32'h0000_0000;
        av[1] = 32'hFFFF_FFFF; bv[1] = 32'd2;         cv[1] = 32'hFFFF_FFFE;
        for (int t = 0; t < 2; t++) begin
            for (int e = 0; e < E; e++) begin ma[e] = 0; mb[e] = 0; end
            ma[0] = av[t];
            mb[0] = bv[t];
            model(1'b0);
            load_in();
            launch0(lat, bc);
            n_cmp++;
            if (out0[W-1:0] !== cv[t]) begin
                n_bad++;
                $display("FAIL wrap%0d_c00: got %h want %h", t, out0[W-1:0], cv[t]);
            end
            for (int e = 0; e < E; e++) begin
                n_cmp++;
                if (out0[e*W +: W] !== exp_c[e]) begin
                    n_bad++;
                    $display("FAIL wrap%0d_c%0d: got %h want %h", t, e, out0[e*W +: W], exp_c[e]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        for (int t = 0; t < 4; t++) begin
            for (int e = 0; e < E; e++) begin ma[e] = $urandom; mb[e] = $urandom; end
            model(1'b0);
            load_in();
            launch0(lat, bc);
            in_m = {$urandom, $urandom, $urandom};
            n_cmp++;
            if (lat !== 5) begin n_bad++; $display("FAIL b2b%0d_latency: got %0d want 5", t, lat); end
            for (int e = 0; e < E; e++) begin
                n_cmp++;
                if (out0[e*W +: W] !== exp_c[e]) begin
                    n_bad++;
                    $display("FAIL b2b%0d_c%0d: got %h want %h", t, e, out0[e*W +: W], exp_c[e]);
                end
            end
        end
    endtask

    task automatic test_lanes1_ignore();
        int lat, bc;
        for (int e = 0; e < E; e++) begin ma[e] = $urandom; mb[e] = $urandom; end
        model(1'b0);
        load_in();
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        bc  = busy1 ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 2) begin
                start1 = 1'b1;
                for (int e = 0; e < 2*E; e++) in_m[e*W +: W] = $urandom;
            end else begin
                start1 = 1'b0;
            end
            if (busy1) bc++;
            if (done1) break;
        end
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (lat !== 17) begin n_bad++; $display("FAIL l1_latency: got %0d want 17", lat); end
        if (bc !== 16)  begin n_bad++; $display("FAIL l1_busy_cycles: got %0d want 16", bc); end
        if (done1 !== 1'b1) begin n_bad++; $display("FAIL l1_done_hold: got %b want 1", done1); end
        for (int e = 0; e < E; e++) begin
            n_cmp++;
            if (out1[e*W +: W] !== exp_c[e]) begin
                n_bad++;
                $display("FAIL l1_c%0d: got %h want %h", e, out1[e*W +: W], exp_c[e]);
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat, bc;
        for (int e = 0; e < E; e++) begin ma[e] = $urandom | 1; mb[e] = $urandom | 1; end
        load_in();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp += 3;
        if (out0 !== '0)    begin n_bad++; $display("FAIL rstmid_out: got nonzero want 0"); end
        if (done0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done0); end
        if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < E; e++) begin ma[e] = $urandom; mb[e] = $urandom; end
        model(1'b0);
        load_in();
        launch0(lat, bc);
        n_cmp++;
        if (lat !== 5) begin n_bad++; $display("FAIL rstmid_relatency: got %0d want 5", lat); end
        for (int e = 0; e < E; e++) begin
            n_cmp++;
            if (out0[e*W +: W] !== exp_c[e]) begin
                n_bad++;
                $display("FAIL rstmid_c%0d: got %h want %h", e, out0[e*W +: W], exp_c[e]);
            end
        end
    endtask

`ifdef MATMUL_ACC_EN
    task automatic test_acc();
        int lat, bc;
        bit [2:0] modes;
        modes = 3'b011;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < E; e++) begin
            ma[e] = (e / D == e % D) ? 32'd1 : 32'd0;
            mb[e] = ma[e];
            exp_c[e] = 32'd0;
        end
        load_in();
        for (int t = 0; t < 3; t++) begin
            acc_mode = modes[t];
            model(modes[t]);
            launch0(lat, bc);
            for (int e = 0; e < E; e++) begin
                n_cmp++;
                if (out0[e*W +: W] !== exp_c[e]) begin
                    n_bad++;
                    $display("FAIL acc%0d_c%0d: got %h want %h", t, e, out0[e*W +: W], exp_c[e]);
                end
            end
        end
        acc_mode = 1'b0;
    endtask
`endif

    initial begin
        reset  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        in_m   = '0;
`ifdef MATMUL_ACC_EN
        acc_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_identity();
        test_const_hold();
        test_wrap();
        test_back_to_back();
        test_lanes1_ignore();
        test_reset_mid_calc();
`ifdef MATMUL_ACC_EN
        test_acc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
Parametrised successor to the fixed 4x4 matrix I/O block. Computes C = A x B for square DIM x DIM integer matrices by time-multiplexing LANES dot-product units over the DIM*DIM output elements. Operands are captured on start, and the result is held registered until the next start. Sits between the AFU data path (operand line in) and the result write-back path.

Parameters:
DIM, 4, matrix dimension (rows = cols); legal range 2..16.
DATA_W, 32, element width in bits.
LANES, 4, output elements computed per cycle; must divide DIM*DIM (elaboration error otherwise).

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
in_matrix  input  2*DIM*DIM*DATA_W  operands: A in the low half, B in the high half; both row-major, element (r,c) at [(r*DIM+c)*DATA_W +: DATA_W] within its half.
busy  output  1  high while computing.
done  output  1  result valid; level, held until next accepted start.
out_matrix  output  DIM*DIM*DATA_W  C, row-major, same element layout.

Behaviour:
- Reset values (asynchronous, active-low): state = IDLE, busy = 0, done = 0, out_matrix = 0, element index = 0, operand registers = 0.
- States:
  - IDLE: start=1 captures in_matrix into the operand registers, clears the index, and moves to CALC.
  - CALC: busy=1. Each cycle writes elements idx..idx+LANES-1 of out_matrix, then idx += LANES. Once the write to element DIM*DIM-1 is done, moves to DONE.
  - DONE: done=1, busy=0. start=1 recaptures operands, moves to CALC, and drops done on the next cycle.
- Latency: an accepted start at edge t gives CALC for DIM*DIM/LANES cycles, with done=1 visible after edge t+DIM*DIM/LANES+1. Defaults give 5 cycles; LANES=1 gives 17.
- Operands are registered at start; in_matrix may change freely afterwards.
- start while in CALC is ignored (not queued).
- Element c(r,k) = sum over j of a(r,j)*b(j,k). B is indexed by column internally; the caller does not transpose.
- Arithmetic: products and sums are truncated modulo 2^DATA_W. Low bits are identical for signed and unsigned operands. No overflow flag.
- out_matrix is only valid while done=1. During CALC it holds a mix of new and previous elements (deterministic but not to be consumed).
- Reset asserted mid-CALC: immediate return to IDLE with outputs zeroed; the partial result is discarded.
- Reset deasserted while start is high: start is sampled on the first clock edge after release.

Optional Feature:
MATMUL_ACC_EN
- When defined: adds input port acc_mode (1 bit), sampled together with start. If acc_mode=1, each element is written as its previous out_matrix value plus the dot product, modulo 2^DATA_W (C += A x B). If acc_mode=0, behaviour is as without the macro.
- When undefined: the port is absent, and every computation overwrites out_matrix.

Decomposition:
- Package matmul_pkg holds:
  - the state encoding (IDLE, CALC, DONE);
  - localparams ELEMS = DIM*DIM, STEPS = ELEMS/LANES, IDX_W = clog2(ELEMS).
- Sub-module matmul_dot: a combinational DIM-wide dot product of one A row and one B column (DIM multipliers plus an adder tree, DATA_W-truncated). It is instantiated LANES times; row/column select logic stays in the parent.

Test Plan:
- Defaults, A = identity, B = 1..16 row-major, start pulse -> done rises 5 cycles after start, out_matrix = B, busy high for exactly 4 cycles.
- A all 2, B all 3 -> every element = 24 (0x18); done holds until the next start.
- Wrap: a(0,0) = 0x0001_0000, b(0,0) = 0x0001_0000, all else 0 -> c(0,0) = 0x0000_0000; a(0,0) = 0xFFFF_FFFF, b(0,0) = 2 -> c(0,0) = 0xFFFF_FFFE.
- LANES=1, DIM=4 -> done 17 cycles after start. Second start asserted in CALC cycle 3 is ignored, and the result matches the first operand set even though in_matrix was changed after start.
- Reset pulsed low in CALC cycle 2 -> out_matrix = 0, done = 0, busy = 0 immediately. A fresh start then completes normally.
- MATMUL_ACC_EN: A = B = identity, acc_mode=1 run twice -> diagonal = 2, off-diagonal = 0. A third run with acc_mode=0 -> identity.
